// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding a 2-bit UART transmitter with timeout and inter-frame gap
module uart_tx_scheduler #(
  parameter int NREQ = 4,
  parameter int GAP_CYCLES = 576,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              sched_en,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [1:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic [2:0]        sel_id,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       frame_cnt
);
  typedef enum logic [2:0] {IDLE, ARB, START, WAIT, GAP} state_t;
  localparam int MAXC = TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] rr_ptr, rr_n, pick, pick_hi, pick_lo;
  logic [1:0] data_hi, data_lo, pick_data;
  logic found_hi, arb_go, cnt_to, cnt_gap, wait_exit;
  logic [NREQ-1:0] grant_n;
  logic tx_start_n, busy_n, terr_n;
  logic [1:0] tx_data_n;
  logic [2:0] sel_n;
  logic [15:0] fcnt_n;
  assign cnt_to = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_gap = cnt == CW'(GAP_CYCLES - 1);
  assign arb_go = state == ARB && |req;
  assign wait_exit = state == WAIT && (tx_done || cnt_to);
  assign pick = found_hi ? pick_hi : pick_lo;
  assign pick_data = found_hi ? data_hi : data_lo;
  // round-robin search: lowest requester at or above rr_ptr, else lowest overall (wrap)
  always_comb begin
    found_hi = 1'b0;
    pick_hi = '0;
    pick_lo = '0;
    data_hi = '0;
    data_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_lo = 3'(i);
        data_lo = req_data[2*i +: 2];
        if (3'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          pick_hi = 3'(i);
          data_hi = req_data[2*i +: 2];
        end
      end
    end
  end
  // state register, shared wait/gap counter and round-robin pointer
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state <= IDLE;
      cnt <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == START || wait_exit) ? '0 : cnt + 1'b1;
      rr_ptr <= rr_n;
    end
  end
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (sched_en && |req && !tx_busy) ? ARB : IDLE;
      ARB:     state_n = |req ? START : IDLE;
      START:   state_n = WAIT;
      WAIT:    state_n = (tx_done || cnt_to) ? GAP : WAIT;
      GAP:     state_n = cnt_gap ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  // next values of the registered outputs; tx_done only counts while waiting
  always_comb begin
    grant_n = arb_go ? NREQ'(1) << pick : '0;
    tx_start_n = arb_go;
    tx_data_n = arb_go ? pick_data : tx_data;
    sel_n = arb_go ? pick : sel_id;
    busy_n = state_n != IDLE;
    terr_n = timeout_err | (state == WAIT && !tx_done && cnt_to);
    fcnt_n = frame_cnt + 16'(state == WAIT && tx_done);
    rr_n = wait_exit ? (sel_id == 3'(NREQ - 1) ? 3'd0 : sel_id + 3'd1) : rr_ptr;
  end
  // output registers
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      grant <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      sel_id <= '0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      grant <= grant_n;
      tx_start <= tx_start_n;
      tx_data <= tx_data_n;
      sel_id <= sel_n;
      busy <= busy_n;
      timeout_err <= terr_n;
      frame_cnt <= fcnt_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: table-driven and scoreboard checks of the UART transmit scheduler
module tb_uart_tx_scheduler;
  logic sys_clk = 1'b0, sys_reset = 1'b1, sched_en = 1'b1, tx_busy = 1'b0, tx_done = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] req_data = '0;
  logic [3:0] grant;
  logic tx_start, busy, timeout_err;
  logic [1:0] tx_data;
  logic [2:0] sel_id;
  logic [15:0] frame_cnt;
  int pass_cnt = 0, total_cnt = 0;
  typedef struct {
    logic [3:0] req;
    logic [7:0] data;
    logic [3:0] grant;
    logic [1:0] txd;
    logic [2:0] sel;
    int delay;
  } vec_t;
  typedef struct {
    logic [3:0] grant;
    logic [1:0] txd;
    logic [2:0] sel;
  } exp_t;
  vec_t vecs[9];
  exp_t sb[$];

  uart_tx_scheduler dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .sched_en(sched_en), .req(req),
    .req_data(req_data), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .sel_id(sel_id), .busy(busy),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic do_reset;
    req = '0;
    tx_done = 1'b0;
    tx_busy = 1'b0;
    sched_en = 1'b1;
    sys_reset = 1'b1;
    tick;
    tick;
    sys_reset = 1'b0;
  endtask

  task automatic send(input logic [3:0] r, input logic [7:0] d, input logic [3:0] g,
                      input logic [1:0] t, input logic [2:0] s);
    exp_t e;
    e.grant = g;
    e.txd = t;
    e.sel = s;
    sb.push_back(e);
    req = r;
    req_data = d;
  endtask

  // waits for tx_start, compares against the scoreboard head, then withdraws the request
  task automatic expect_start;
    int n;
    exp_t e;
    n = 0;
    while (!tx_start && n < 10) begin
      tick;
      n++;
    end
    chk("start_latency", n, 2);
    e = sb.pop_front();
    chk("grant", grant, e.grant);
    chk("tx_data", tx_data, e.txd);
    chk("sel_id", sel_id, e.sel);
    req = '0;
    req_data = ~req_data;
    tick;
    chk("start_pulse_width", {grant, tx_start}, 0);
  endtask

  task automatic finish_frame(input int d, output int n);
    repeat (d) tick;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    n = 0;
    while (busy && n < 5000) begin
      tick;
      n++;
    end
  endtask

  initial begin
    int n;
    bit seen;
    vecs[0] = '{4'hF, 8'hE4, 4'h1, 2'd0, 3'd0, 5};
    vecs[1] = '{4'hF, 8'hE4, 4'h2, 2'd1, 3'd1, 5};
    vecs[2] = '{4'hF, 8'hE4, 4'h4, 2'd2, 3'd2, 5};
    vecs[3] = '{4'hF, 8'hE4, 4'h8, 2'd3, 3'd3, 5};
    vecs[4] = '{4'hF, 8'hE4, 4'h1, 2'd0, 3'd0, 5};
    vecs[5] = '{4'h5, 8'hE4, 4'h4, 2'd2, 3'd2, 7};
    vecs[6] = '{4'h3, 8'h1B, 4'h1, 2'd3, 3'd0, 9};
    vecs[7] = '{4'h2, 8'h08, 4'h2, 2'd2, 3'd1, 600};
    vecs[8] = '{4'h8, 8'h40, 4'h8, 2'd1, 3'd3, 3};
    do_reset;
    chk("reset_outputs", {grant, tx_start, tx_data, sel_id, busy, timeout_err}, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].req, vecs[i].data, vecs[i].grant, vecs[i].txd, vecs[i].sel);
      expect_start;
      finish_frame(vecs[i].delay, n);
      chk("gap_length", n, 576);
      chk("frame_cnt", frame_cnt, i + 1);
      chk("hold_tx_data", tx_data, vecs[i].txd);
      chk("hold_sel_id", sel_id, vecs[i].sel);
    end
    do_reset;
    send(4'h1, 8'h03, 4'h1, 2'd3, 3'd0);
    expect_start;
    n = 1;
    while (!timeout_err && n < 6000) begin
      tick;
      n++;
    end
    chk("timeout_clocks", n, 4097);
    chk("timeout_frame_cnt", frame_cnt, 0);
    finish_frame(0, n);
    chk("timeout_sticky", timeout_err, 1);
    send(4'h3, 8'h0C, 4'h2, 2'd3, 3'd1);
    expect_start;
    finish_frame(4, n);
    chk("timeout_still_sticky", timeout_err, 1);
    chk("after_timeout_cnt", frame_cnt, 1);
    do_reset;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("done_in_idle_ignored", frame_cnt, 0);
    send(4'h4, 8'h30, 4'h4, 2'd3, 3'd2);
    expect_start;
    repeat (4095) tick;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("collision_cnt", frame_cnt, 1);
    chk("collision_no_err", timeout_err, 0);
    tick;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("done_in_gap_ignored", frame_cnt, 1);
    finish_frame(0, n);
    chk("collision_end_cnt", frame_cnt, 1);
    do_reset;
    sched_en = 1'b0;
    req = 4'h4;
    req_data = 8'h20;
    repeat (5) tick;
    chk("gated_no_grant", {busy, tx_start, grant}, 0);
    sched_en = 1'b1;
    send(4'h4, 8'h20, 4'h4, 2'd2, 3'd2);
    expect_start;
    sched_en = 1'b0;
    finish_frame(10, n);
    chk("gated_frame_done", frame_cnt, 1);
    sched_en = 1'b1;
    tx_busy = 1'b1;
    req = 4'h1;
    req_data = 8'h01;
    repeat (5) tick;
    chk("tx_busy_blocks", {busy, tx_start}, 0);
    tx_busy = 1'b0;
    send(4'h1, 8'h01, 4'h1, 2'd1, 3'd0);
    expect_start;
    finish_frame(2, n);
    chk("tx_busy_frame_cnt", frame_cnt, 2);
    do_reset;
    send(4'h8, 8'hC0, 4'h8, 2'd3, 3'd3);
    expect_start;
    repeat (10) tick;
    #2;
    sys_reset = 1'b1;
    #1;
    chk("async_reset_outputs", {grant, tx_start, tx_data, sel_id, busy, timeout_err}, 0);
    chk("async_reset_cnt", frame_cnt, 0);
    tick;
    sys_reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick;
      if (tx_start || busy) seen = 1'b1;
    end
    chk("no_start_after_reset", seen, 0);
    send(4'h2, 8'h04, 4'h2, 2'd1, 3'd1);
    expect_start;
    finish_frame(3, n);
    chk("post_reset_frame", frame_cnt, 1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
